// File: rtl/cim_core_mem_arbiter.sv
// rtl/cim_core_mem_arbiter.sv - round-robin arbiter for the shared CIM core memory port
module cim_core_mem_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int READ_LATENCY   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*MEM_DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [MEM_DATA_WIDTH-1:0]           rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [MEM_DATA_WIDTH/8-1:0]         mem_be_o,
    output logic [MEM_DATA_WIDTH-1:0]           mem_data_o,
    input  logic [MEM_DATA_WIDTH-1:0]           mem_data_i
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BE_W = MEM_DATA_WIDTH / 8;

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    grant;
    int                      idx;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_rd;
    logic [ID_W-1:0]         pipe_id [READ_LATENCY];

    // Search requesters starting at rr_ptr, wrapping modulo NUM_REQ; first hit wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // No grant is issued while reset is held, even with requests pending
    assign grant = found && rst_ni;

    // Forward the winner's access unchanged; idle port drives all zeros
    always_comb begin
        gnt_o      = '0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_be_o   = '0;
        mem_data_o = '0;
        if (grant) begin
            gnt_o[winner] = 1'b1;
            mem_req_o     = 1'b1;
            mem_we_o      = we_i[winner];
            mem_addr_o    = addr_i[int'(winner)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            mem_be_o      = be_i[int'(winner)*BE_W +: BE_W];
            mem_data_o    = wdata_i[int'(winner)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next time
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Fixed-latency response tracker: one entry per grant, shifted every cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_rd    <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= grant;
            pipe_rd[0]    <= grant && !we_i[winner];
            pipe_id[0]    <= winner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rd[i]    <= pipe_rd[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    // Completion pulse to the issuer; read data only for reads, zero for write acks
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pipe_valid[READ_LATENCY-1]) begin
            rvalid_o[pipe_id[READ_LATENCY-1]] = 1'b1;
            if (pipe_rd[READ_LATENCY-1]) begin
                rdata_o = mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_cim_core_mem_arbiter.sv
// tb/tb_cim_core_mem_arbiter.sv - directed vector bench for cim_core_mem_arbiter
module tb_cim_core_mem_arbiter;

    logic        clk;
    logic        rst_ni;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [95:0] addr;
    logic [11:0] be;
    logic [95:0] wdata;
    logic [31:0] mdata1;
    logic [31:0] mdata3;

    logic [2:0]  gnt1, rvalid1, gnt3, rvalid3;
    logic [31:0] rdata1, rdata3;
    logic        mreq1, mwe1, mreq3, mwe3;
    logic [31:0] maddr1, mwd1, maddr3, mwd3;
    logic [3:0]  mbe1, mbe3;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] a_tab [3] = '{32'h0000_0040, 32'h0000_0100, 32'h0000_0200};
    logic [31:0] d_tab [3] = '{32'h0000_00AA, 32'h1111_1111, 32'h2222_2222};
    logic [3:0]  b_tab [3] = '{4'b0001, 4'b1111, 4'b1010};

    cim_core_mem_arbiter #(.NUM_REQ(3), .MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
        .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_be_o(mbe1),
        .mem_data_o(mwd1), .mem_data_i(mdata1)
    );

    cim_core_mem_arbiter #(.NUM_REQ(3), .MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_be_o(mbe3),
        .mem_data_o(mwd3), .mem_data_i(mdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [31:0] mdata;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        req    = 3'b000;
        we     = 3'b000;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_we;
        logic [2:0]  rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        for (int k = 0; k < 3; k++) begin
            addr[k*32 +: 32] = a_tab[k];
            wdata[k*32 +: 32] = d_tab[k];
            be[k*4 +: 4] = b_tab[k];
        end
        mdata1 = 32'h0;
        mdata3 = 32'h0;

        // reset held with all requesters active: nothing granted or returned
        rst_ni = 1'b0;
        req    = 3'b111;
        we     = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rst_gnt",    32'(gnt1),    32'h0);
            check("rst_mreq",   32'(mreq1),   32'h0);
            check("rst_rvalid", 32'(rvalid1), 32'h0);
            check("rst_maddr",  maddr1,       32'h0);
            check("rst_rdata",  rdata1,       32'h0);
            check("rst_gnt3",   32'(gnt3),    32'h0);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        req    = 3'b000;

        // read, round robin, wrap/skip and mixed write/read traffic (latency 1)
        vecs[0]  = '{3'b010, 3'b000, 32'h0,         3'b010, 3'b000, 32'h0};
        vecs[1]  = '{3'b000, 3'b000, 32'hDEADBEEF,  3'b000, 3'b010, 32'hDEADBEEF};
        vecs[2]  = '{3'b111, 3'b000, 32'h0,         3'b100, 3'b000, 32'h0};
        vecs[3]  = '{3'b111, 3'b000, 32'h33,        3'b001, 3'b100, 32'h33};
        vecs[4]  = '{3'b111, 3'b000, 32'h44,        3'b010, 3'b001, 32'h44};
        vecs[5]  = '{3'b011, 3'b000, 32'h55,        3'b001, 3'b010, 32'h55};
        vecs[6]  = '{3'b011, 3'b000, 32'h66,        3'b010, 3'b001, 32'h66};
        vecs[7]  = '{3'b001, 3'b001, 32'h77,        3'b001, 3'b010, 32'h77};
        vecs[8]  = '{3'b100, 3'b000, 32'h88,        3'b100, 3'b001, 32'h0};
        vecs[9]  = '{3'b000, 3'b000, 32'h99,        3'b000, 3'b100, 32'h99};
        vecs[10] = '{3'b000, 3'b000, 32'hAB,        3'b000, 3'b000, 32'h0};

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            req    = vecs[v].req;
            we     = vecs[v].we;
            mdata1 = vecs[v].mdata;
            #1;
            e_addr = 32'h0; e_wd = 32'h0; e_be = 4'h0; e_we = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (vecs[v].exp_gnt[k]) begin
                    e_addr = a_tab[k]; e_wd = d_tab[k]; e_be = b_tab[k]; e_we = vecs[v].we[k];
                end
            end
            check($sformatf("v%0d_gnt", v),    32'(gnt1),    32'(vecs[v].exp_gnt));
            check($sformatf("v%0d_rvalid", v), 32'(rvalid1), 32'(vecs[v].exp_rvalid));
            check($sformatf("v%0d_rdata", v),  rdata1,       vecs[v].exp_rdata);
            check($sformatf("v%0d_mreq", v),   32'(mreq1),   32'(vecs[v].exp_gnt != 3'b000));
            check($sformatf("v%0d_maddr", v),  maddr1,       e_addr);
            check($sformatf("v%0d_mwe", v),    32'(mwe1),    32'(e_we));
            check($sformatf("v%0d_mbe", v),    32'(mbe1),    32'(e_be));
            check($sformatf("v%0d_mwd", v),    mwd1,         e_wd);
        end

        // round robin from reset: all three held for six cycles
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = 3'b111;
            #1;
            check($sformatf("rr%0d_gnt", c), 32'(gnt1),  32'(rr_exp[c]));
            check($sformatf("rr%0d_mreq", c), 32'(mreq1), 32'h1);
        end

        // latency 3: write ack then read data, same order, three cycles after grant
        apply_reset();
        @(negedge clk);
        req = 3'b001; we = 3'b001; #1;
        check("l3_gnt_w", 32'(gnt3), 32'h1);
        check("l3_mbe_w", 32'(mbe3), 32'h1);
        @(negedge clk);
        req = 3'b100; we = 3'b000; #1;
        check("l3_gnt_r", 32'(gnt3), 32'h4);
        check("l3_rv_c1", 32'(rvalid3), 32'h0);
        @(negedge clk);
        req = 3'b000; #1;
        check("l3_rv_c2", 32'(rvalid3), 32'h0);
        @(negedge clk);
        mdata3 = 32'h1234_5678; #1;
        check("l3_rv_ack", 32'(rvalid3), 32'h1);
        check("l3_rd_ack", rdata3,       32'h0);
        @(negedge clk);
        mdata3 = 32'hCAFE_F00D; #1;
        check("l3_rv_rd", 32'(rvalid3), 32'h4);
        check("l3_rd_rd", rdata3,       32'hCAFE_F00D);
        @(negedge clk);
        mdata3 = 32'h5555_5555; #1;
        check("l3_rv_end", 32'(rvalid3), 32'h0);
        check("l3_rd_end", rdata3,       32'h0);

        // reset while reads are in flight drops their responses
        apply_reset();
        @(negedge clk);
        req = 3'b010; we = 3'b000; mdata1 = 32'hFFFF_FFFF; mdata3 = 32'hFFFF_FFFF; #1;
        check("mf_gnt", 32'(gnt1), 32'h2);
        @(negedge clk);
        req = 3'b000;
        rst_ni = 1'b0; #1;
        check("mf_rv_rst", 32'(rvalid1), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("mf%0d_rv1", c), 32'(rvalid1), 32'h0);
            check($sformatf("mf%0d_rv3", c), 32'(rvalid3), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
